// File: rtl/fpu_ss_issue_buffer.sv
// fpu_ss_issue_buffer: in-order issue buffer between X-interface issue and FPU controller, with kill-in-place
// Ports: clk_i/rst_i (sync, active-high); push_valid_i/push_ready_o/push_id_i/push_data_i (issue side);
// pop_valid_o/pop_ready_i/pop_id_o/pop_data_o (controller side); commit_valid_i/commit_id_i/commit_kill_i;
// usage_o registered occupancy. Define FPU_SS_ISSUE_BUF_BYPASS_EN for empty-buffer fall-through.
module fpu_ss_issue_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned X_ID_WIDTH    = 4,
  parameter int unsigned PAYLOAD_WIDTH = 128
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [X_ID_WIDTH-1:0]        push_id_i,
  input  logic [PAYLOAD_WIDTH-1:0]     push_data_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [X_ID_WIDTH-1:0]        pop_id_o,
  output logic [PAYLOAD_WIDTH-1:0]     pop_data_o,
  input  logic                         commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]        commit_id_i,
  input  logic                         commit_kill_i,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  logic [X_ID_WIDTH-1:0]    id_q   [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]         killed_q, killed_d;
  logic [PW-1:0]            wr_q, rd_q, off;
  logic [CW-1:0]            count_q, count_d;
  logic                     kill, push_kill, empty, drop, push_hs, pop_hs, store, byp;
  assign kill         = commit_valid_i & commit_kill_i;
  assign push_kill    = kill & (commit_id_i == push_id_i);
  assign empty        = count_q == '0;
  assign drop         = ~empty & killed_q[rd_q];
  assign push_ready_o = count_q != CW'(DEPTH);
  assign push_hs      = push_valid_i & push_ready_o;
`ifdef FPU_SS_ISSUE_BUF_BYPASS_EN
  assign byp = empty & push_valid_i & ~push_kill;
`else
  assign byp = 1'b0;
`endif
  assign pop_valid_o = byp | (~empty & ~killed_q[rd_q]);
  assign pop_id_o    = byp ? push_id_i : id_q[rd_q];
  assign pop_data_o  = byp ? push_data_i : data_q[rd_q];
  // a fall-through consumed in the same cycle never touches storage
  assign pop_hs  = ~byp & pop_valid_o & pop_ready_i;
  assign store   = push_hs & ~(byp & pop_ready_i);
  assign count_d = count_q + CW'(store) - CW'(pop_hs | drop);
  assign usage_o = count_q;
  // kill only marks slots inside the occupied window [rd, rd+count)
  always_comb begin
    killed_d = killed_q;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if (kill && id_q[i] == commit_id_i && CW'(off) < count_q) killed_d[i] = 1'b1;
    end
    if (store) killed_d[wr_q] = push_kill;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      killed_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_q     <= wr_q + PW'(store);
      rd_q     <= rd_q + PW'(pop_hs | drop);
      count_q  <= count_d;
      killed_q <= killed_d;
      if (store) begin
        id_q[wr_q]   <= push_id_i;
        data_q[wr_q] <= push_data_i;
      end
    end
  end
endmodule
